hazard_stall_ctrl: RTL and testbench

- Central pipeline sequencer for the 16-bit five-stage core.
- Drives the write-enable ("stall" pin, 1 = capture) of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers, plus the IF/ID flush and ID/EX bubble controls.
- Resolves load-use hazards, instruction/data memory wait states, taken-branch flushes and halt.
- Keeps a saturating stall-cycle counter and a data-memory timeout error flag.

---
 rtl/hazard_stall_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Central pipeline sequencer for the 16-bit five-stage core. It produces the
//   write enables of the PC and the four pipeline buffers, plus the IF/ID flush
//   and ID/EX bubble. It resolves load-use hazards, instruction and data
//   memory wait states, taken-branch flushes and halt. It also keeps a
//   saturating stall-cycle counter and a sticky data-memory timeout flag.
//
// Ports
//   clk, rst (async, active-low)
//   IDEX_memread, IDEX_rt          : load in EX and its destination register
//   IFID_rs, IFID_rt, IFID_uses_rt : source registers of the instruction in ID
//   branch_taken                   : branch resolved taken in ID
//   imem_ready                     : fetch data valid this cycle
//   EXMEM_memaccess, dmem_ready    : data-memory access in MEM and its completion
//   MEMWB_halt                     : HLT instruction in WB
//   pc_wen .. MEMWB_wen            : stage write enables (1 = capture)
//   IFID_flush, IDEX_bubble        : NOP injection into IF/ID and ID/EX
//   halted, mem_err, stall_count   : status outputs
module hazard_stall_ctrl #(
  parameter int unsigned REG_W   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_memread,
  input  logic [REG_W-1:0] IDEX_rt,
  input  logic [REG_W-1:0] IFID_rs,
  input  logic [REG_W-1:0] IFID_rt,
  input  logic             IFID_uses_rt,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             EXMEM_memaccess,
  input  logic             dmem_ready,
  input  logic             MEMWB_halt,
  output logic             pc_wen,
  output logic             IFID_wen,
  output logic             IDEX_wen,
  output logic             EXMEM_wen,
  output logic             MEMWB_wen,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

  state_t          state, next_state;
  logic [WC_W-1:0] wait_cnt;
  logic            dwait, lduse, iwait, timeout;

  assign dwait = EXMEM_memaccess & ~dmem_ready;
  assign lduse = IDEX_memread &
                 ((IDEX_rt == IFID_rs) | (IFID_uses_rt & (IDEX_rt == IFID_rt)));
  assign iwait = ~imem_ready;

  assign halted = (state == HALTED);

  // RUN and DWAIT share output rules: the DWAIT release cycle (dwait=0)
  // behaves exactly like RUN, so only HALTED and dwait need special casing.
  always_comb begin
    pc_wen      = 1'b0;
    IFID_wen    = 1'b0;
    IDEX_wen    = 1'b0;
    EXMEM_wen   = 1'b0;
    MEMWB_wen   = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    next_state  = state;
    timeout     = 1'b0;
    if (state == HALTED) begin
      next_state = HALTED;
    end else if (dwait) begin
      next_state = DWAIT;
      if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
        timeout    = 1'b1;
        next_state = HALTED;
      end
    end else begin
      next_state = MEMWB_halt ? HALTED : RUN;
      IDEX_wen   = 1'b1;
      EXMEM_wen  = 1'b1;
      MEMWB_wen  = 1'b1;
      if (lduse) begin
        IDEX_bubble = 1'b1;
      end else if (iwait) begin
        // IF/ID must capture so the flush NOP actually lands
        IFID_wen   = 1'b1;
        IFID_flush = 1'b1;
      end else begin
        pc_wen     = 1'b1;
        IFID_wen   = 1'b1;
        IFID_flush = branch_taken;
      end
    end
    if (!rst) begin
      pc_wen      = 1'b0;
      IFID_wen    = 1'b0;
      IDEX_wen    = 1'b0;
      EXMEM_wen   = 1'b0;
      MEMWB_wen   = 1'b0;
      IFID_flush  = 1'b0;
      IDEX_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_count <= '0;
      mem_err     <= 1'b0;
    end else begin
      state <= next_state;
      if (dwait && (state != HALTED) && !timeout)
        wait_cnt <= wait_cnt + WC_W'(1);
      else
        wait_cnt <= '0;
      if (timeout)
        mem_err <= 1'b1;
      if (!pc_wen && (state != HALTED) && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;

  localparam logic [6:0] V_NORM  = 7'b11111_00;
  localparam logic [6:0] V_LDUSE = 7'b00111_01;
  localparam logic [6:0] V_IWAIT = 7'b01111_10;
  localparam logic [6:0] V_BR    = 7'b11111_10;
  localparam logic [6:0] V_OFF   = 7'b00000_00;

  logic             clk = 1'b0;
  logic             rst;
  logic             IDEX_memread;
  logic [REG_W-1:0] IDEX_rt, IFID_rs, IFID_rt;
  logic             IFID_uses_rt, branch_taken, imem_ready;
  logic             EXMEM_memaccess, dmem_ready, MEMWB_halt;
  logic             pc_wen, IFID_wen, IDEX_wen, EXMEM_wen, MEMWB_wen;
  logic             IFID_flush, IDEX_bubble, halted, mem_err;
  logic [CNT_W-1:0] stall_count;
  logic [6:0]       vec;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  hazard_stall_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .IDEX_memread(IDEX_memread), .IDEX_rt(IDEX_rt),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_uses_rt(IFID_uses_rt),
    .branch_taken(branch_taken), .imem_ready(imem_ready),
    .EXMEM_memaccess(EXMEM_memaccess), .dmem_ready(dmem_ready),
    .MEMWB_halt(MEMWB_halt),
    .pc_wen(pc_wen), .IFID_wen(IFID_wen), .IDEX_wen(IDEX_wen),
    .EXMEM_wen(EXMEM_wen), .MEMWB_wen(MEMWB_wen),
    .IFID_flush(IFID_flush), .IDEX_bubble(IDEX_bubble),
    .halted(halted), .mem_err(mem_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign vec = {pc_wen, IFID_wen, IDEX_wen, EXMEM_wen, MEMWB_wen, IFID_flush, IDEX_bubble};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    IDEX_memread    = 1'b0;
    IDEX_rt         = 4'd0;
    IFID_rs         = 4'd1;
    IFID_rt         = 4'd2;
    IFID_uses_rt    = 1'b0;
    branch_taken    = 1'b0;
    imem_ready      = 1'b1;
    EXMEM_memaccess = 1'b0;
    dmem_ready      = 1'b1;
    MEMWB_halt      = 1'b0;
  endtask

  // advance one clock edge; inputs are driven 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2;
    chk("rst_vec", 32'(vec), 32'(V_OFF));
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_count", 32'(stall_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // free run
    for (int i = 0; i < 10; i++) begin
      #2 chk("free_vec", 32'(vec), 32'(V_NORM));
      step();
    end
    chk("free_count", 32'(stall_count), 32'd0);

    // load-use on rs
    IDEX_memread = 1'b1; IDEX_rt = 4'd3; IFID_rs = 4'd3;
    #2 chk("lduse_rs_vec", 32'(vec), 32'(V_LDUSE));
    step();
    chk("lduse_rs_count", 32'(stall_count), 32'd1);
    // rt matches but not used
    IFID_rs = 4'd5; IFID_rt = 4'd3; IFID_uses_rt = 1'b0;
    #2 chk("lduse_rt_unused_vec", 32'(vec), 32'(V_NORM));
    step();
    chk("lduse_rt_unused_count", 32'(stall_count), 32'd1);
    IFID_uses_rt = 1'b1;
    #2 chk("lduse_rt_used_vec", 32'(vec), 32'(V_LDUSE));
    step();
    chk("lduse_rt_used_count", 32'(stall_count), 32'd2);

    // data wait with lduse and branch underneath, then release
    do_reset();
    step();
    EXMEM_memaccess = 1'b1; dmem_ready = 1'b0;
    IDEX_memread = 1'b1; IDEX_rt = 4'd3; IFID_rs = 4'd3; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 chk("dwait_vec", 32'(vec), 32'(V_OFF));
      step();
    end
    dmem_ready = 1'b1;
    #2 chk("release_vec", 32'(vec), 32'(V_LDUSE));
    step();
    idle();
    chk("dwait_count", 32'(stall_count), 32'd4);
    chk("dwait_no_err", 32'(mem_err), 32'd0);

    // branch alone, then with fetch wait
    branch_taken = 1'b1;
    #2 chk("branch_vec", 32'(vec), 32'(V_BR));
    step();
    chk("branch_count", 32'(stall_count), 32'd4);
    imem_ready = 1'b0;
    #2 chk("branch_iwait_vec", 32'(vec), 32'(V_IWAIT));
    step();
    chk("iwait_count", 32'(stall_count), 32'd5);

    // halt commits, then frozen
    idle();
    MEMWB_halt = 1'b1;
    #2 chk("halt_commit_vec", 32'(vec), 32'(V_NORM));
    chk("halt_commit_halted", 32'(halted), 32'd0);
    step();
    MEMWB_halt = 1'b0;
    chk("halted", 32'(halted), 32'd1);
    imem_ready = 1'b0;
    #2 chk("halted_vec", 32'(vec), 32'(V_OFF));
    step();
    step();
    chk("halted_count_frozen", 32'(stall_count), 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_halted", 32'(halted), 32'd0);
    chk("async_rst_vec", 32'(vec), 32'(V_OFF));
    chk("async_rst_count", 32'(stall_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    step();
    #2 chk("after_rst_vec", 32'(vec), 32'(V_NORM));
    chk("after_rst_halted", 32'(halted), 32'd0);

    // halt is held off by a data wait, commits on the release cycle
    step();
    EXMEM_memaccess = 1'b1; dmem_ready = 1'b0; MEMWB_halt = 1'b1;
    #2 chk("halt_dwait_vec", 32'(vec), 32'(V_OFF));
    step();
    chk("halt_dwait_halted", 32'(halted), 32'd0);
    dmem_ready = 1'b1;
    #2 chk("halt_release_vec", 32'(vec), 32'(V_NORM));
    step();
    chk("halt_release_halted", 32'(halted), 32'd1);

    // data-memory timeout
    do_reset();
    step();
    EXMEM_memaccess = 1'b1; dmem_ready = 1'b0;
    #2 chk("to_wait1_vec", 32'(vec), 32'(V_OFF));
    step();
    chk("to_wait2_err", 32'(mem_err), 32'd0);
    step();
    step();
    chk("to_wait4_err", 32'(mem_err), 32'd0);
    chk("to_wait4_halted", 32'(halted), 32'd0);
    #2 chk("to_wait4_vec", 32'(vec), 32'(V_OFF));
    step();
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    idle();
    #2 chk("to_halted_vec", 32'(vec), 32'(V_OFF));
    step();
    chk("to_err_sticky", 32'(mem_err), 32'd1);
    chk("to_halted_sticky", 32'(halted), 32'd1);

    // counter saturation
    do_reset();
    chk("sat_rst_err", 32'(mem_err), 32'd0);
    step();
    imem_ready = 1'b0;
    repeat (15) step();
    chk("sat_reach", 32'(stall_count), 32'd15);
    repeat (5) step();
    chk("sat_hold", 32'(stall_count), 32'd15);
    #2 chk("sat_vec", 32'(vec), 32'(V_IWAIT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
